vx_tex_req_arb: RTL and testbench
=================================

Name: vx_tex_req_arb

Overview:
- Arbitrates NUM_REQS texture request channels onto one texture-unit request channel.
- Each request carries valid, mask, coords, lod, stage, tag and ready.
- Selection is round-robin. An optional full-throughput skid buffer registers the output.
- Source index is appended to the output tag so the response path can route data back. Sits between per-core texture request ports and the shared texture unit.

Parameters:
- NUM_REQS, 4, number of input request channels (>=1)
- NUM_LANES, 4, lanes per request
- TAG_WIDTH, 8, input tag width
- OUT_BUF, 1, 0 = combinational output path; 1 = 2-entry skid buffer
- DROP_EMPTY, 1, 1 = requests with mask==0 are consumed and not forwarded

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_in_valid  in  NUM_REQS  per-channel valid
- req_in_mask  in  NUM_REQS x NUM_LANES  lane mask
- req_in_coords  in  NUM_REQS x 2 x NUM_LANES x 32  u/v coordinates
- req_in_lod  in  NUM_REQS x NUM_LANES x TEX_LOD_BITS  per-lane LOD
- req_in_stage  in  NUM_REQS x TEX_STAGE_BITS  texture stage
- req_in_tag  in  NUM_REQS x TAG_WIDTH  request tag
- req_in_ready  out  NUM_REQS  per-channel ready
- req_out_valid/mask/coords/lod/stage  out  same widths as one input channel
- req_out_tag  out  TAG_WIDTH+SEL_BITS  {input tag, source index}
- req_out_ready  in  1  downstream ready

Behaviour:
- Interface: clk plus asynchronous active-low reset_n. SEL_BITS = clog2(NUM_REQS), 0 when NUM_REQS==1; then the tag passes unchanged.
- Reset (reset_n low, asynchronous):
  - req_out_valid=0; skid entries empty.
  - Round-robin pointer=0.
  - req_in_ready=0 while reset is asserted.
  - All datapath outputs hold their value but are don't-care while valid=0.
- Arbitration: the grant goes to the first valid channel at or after the pointer, wrapping at NUM_REQS-1 -> 0.
- Pointer update: on an accepted input handshake the pointer becomes granted index+1 (mod NUM_REQS). With no handshake the pointer is unchanged.
- Ready: only the granted channel sees req_in_ready=1, and only when the output stage can accept. All other channels get 0.
- Request stability: a requester keeps its payload stable while valid and not ready. Dropping valid before the handshake is not allowed; an assertion checks this.
- OUT_BUF=0: all paths are combinational, latency 0. stage_ready = req_out_ready.
- OUT_BUF=1, 2-entry skid buffer:
  - Latency 1 cycle.
  - Sustains 1 request/cycle.
  - req_in_ready depends only on registered state: stage_ready = !full. No combinational ready path from req_out_ready to req_in_ready.
  - Full (2 entries): all req_in_ready=0.
  - Simultaneous push and pop when 1 entry is held: occupancy stays 1, order is preserved.
- DROP_EMPTY=1, granted request with mask==0:
  - req_in_ready=1 regardless of output stage.
  - Request consumed, pointer advances, nothing forwarded.
- Ordering: per-channel order is preserved. Cross-channel order follows grant order.
- Reset mid-operation: buffered requests are discarded and no output is produced. Upstream owners must also be reset.

Optional Feature:
- Macro VX_TEX_REQ_ARB_PERF_EN.
- When defined:
  - Output perf_stalls (PERF_CTR_BITS=44): counts cycles with req_out_valid && !req_out_ready.
  - Output perf_reqs (44): counts forwarded output handshakes.
  - Both counters reset to 0 on reset_n and wrap on overflow.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package/define include (VX_tex_define):
  - TEX_LOD_BITS and TEX_STAGE_BITS.
  - tex_req_t packed struct {mask, coords, lod, stage, tag}.
  - PERF_CTR_BITS.
- Sub-module vx_tex_skid_buf: generic 2-entry elastic buffer over DATAW bits, valid/ready on both sides. Instantiated only when OUT_BUF=1.
- The arbiter itself stays inline.

Test Plan:
1. Reset and idle: reset_n low with all inputs valid -> req_in_ready=0 and req_out_valid=0. One cycle after release, channel 0 is granted.
2. Round-robin fairness: NUM_REQS=4, all channels continuously valid, req_out_ready=1 -> output tag index sequence 0,1,2,3,0,... Throughput is 1/cycle after the 1-cycle latency.
3. Backpressure:
   - Setup: req_out_ready=0 for 5 cycles, channel 2 valid with tag 0x5A.
   - During the stall: exactly 2 requests accepted, then all req_in_ready=0.
   - After release: outputs drain in order, first output tag = {0x5A, 2'd2}.
4. Empty mask drop: channel 1 sends mask=4'b0000 then mask=4'b0011 -> first consumed in 1 cycle with no output. Only the second appears, with mask 0011.
5. Simultaneous push/pop: buffer holds 1 entry, output ready and new input valid in the same cycle -> occupancy stays 1, no bubble, order preserved.
6. Mid-operation reset: with 2 buffered entries, pulse reset_n low asynchronously between clock edges -> req_out_valid falls immediately; no stale request emitted after release. With the perf macro defined, perf counters read 0.

Source files
------------

// File: rtl/vx_tex_req_arb_pkg.sv
// -----------------------------------------------------------------------------
// vx_tex_req_arb_pkg
// Shared texture-request definitions for the request arbiter and its skid
// buffer: LOD/stage field widths, the default-configuration request layout,
// perf-counter width, skid-buffer state encoding and a select-width helper.
// -----------------------------------------------------------------------------
package vx_tex_req_arb_pkg;

    localparam int TEX_LOD_BITS   = 4;
    localparam int TEX_STAGE_BITS = 2;
    localparam int PERF_CTR_BITS  = 44;

    localparam int TEX_NUM_LANES  = 4;
    localparam int TEX_TAG_WIDTH  = 8;

    // Field order of a request; the arbiter packs its flat datapath vector
    // in this same order {mask, coords, lod, stage, tag}.
    typedef struct packed {
        logic [TEX_NUM_LANES-1:0]                     mask;
        logic [1:0][TEX_NUM_LANES-1:0][31:0]          coords;
        logic [TEX_NUM_LANES-1:0][TEX_LOD_BITS-1:0]   lod;
        logic [TEX_STAGE_BITS-1:0]                    stage;
        logic [TEX_TAG_WIDTH-1:0]                     tag;
    } tex_req_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    // Width of the source index appended to the tag; zero for a single input.
    function automatic int sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

endpackage

// File: rtl/vx_tex_req_arb_if.sv
// -----------------------------------------------------------------------------
// vx_tex_req_arb_if
// Bundle of N texture request channels (valid/ready handshake plus payload).
//   valid  [N]                       request valid
//   mask   [N][LANES]                lane mask
//   coords [N][2][LANES][32]         u/v coordinates
//   lod    [N][LANES][TEX_LOD_BITS]  per-lane LOD
//   stage  [N][TEX_STAGE_BITS]       texture stage
//   tag    [N][TAGW]                 request tag
//   ready  [N]                       consumer ready
// Modports: master drives the request, slave accepts it.
// -----------------------------------------------------------------------------
interface vx_tex_req_arb_if #(
    parameter int N     = 1,
    parameter int LANES = 4,
    parameter int TAGW  = 8
);
    import vx_tex_req_arb_pkg::*;

    logic [N-1:0]                                valid;
    logic [N-1:0][LANES-1:0]                     mask;
    logic [N-1:0][1:0][LANES-1:0][31:0]          coords;
    logic [N-1:0][LANES-1:0][TEX_LOD_BITS-1:0]   lod;
    logic [N-1:0][TEX_STAGE_BITS-1:0]            stage;
    logic [N-1:0][TAGW-1:0]                      tag;
    logic [N-1:0]                                ready;

    modport master (
        output valid, mask, coords, lod, stage, tag,
        input  ready
    );

    modport slave (
        input  valid, mask, coords, lod, stage, tag,
        output ready
    );

endinterface

// File: rtl/vx_tex_req_arb_skid_buf.sv
// -----------------------------------------------------------------------------
// vx_tex_skid_buf
// Generic 2-entry elastic buffer over DATAW bits. Full throughput (push and
// pop in the same cycle with one entry held), in_ready comes only from
// registered state so there is no combinational ready path through it.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   in_valid/in_data/in_ready    upstream handshake
//   out_valid/out_data/out_ready downstream handshake
//
//   state      | meaning
//   SKID_EMPTY | nothing held, out_valid=0
//   SKID_ONE   | head holds the oldest entry
//   SKID_FULL  | head + spare hold two entries, in_ready=0
// -----------------------------------------------------------------------------
module vx_tex_skid_buf
    import vx_tex_req_arb_pkg::*;
#(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    input  logic             out_ready
);

    skid_state_t      state, state_nxt;
    logic [DATAW-1:0] head, spare;
    logic             push, pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SKID_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SKID_EMPTY: if (push) state_nxt = SKID_ONE;
            SKID_ONE: begin
                if (push && !pop)      state_nxt = SKID_FULL;
                else if (!push && pop) state_nxt = SKID_EMPTY;
            end
            SKID_FULL:  if (pop) state_nxt = SKID_ONE;
            default:    state_nxt = SKID_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == SKID_ONE) || (state == SKID_FULL);
        in_ready  = (state != SKID_FULL);
    end

    // Datapath registers need no reset: contents are ignored while empty.
    always_ff @(posedge clk) begin
        case (state)
            SKID_EMPTY: if (push) head <= in_data;
            SKID_ONE: begin
                if (push && pop) head  <= in_data;
                else if (push)   spare <= in_data;
            end
            SKID_FULL:  if (pop) head <= spare;
            default: ;
        endcase
    end

    assign out_data = head;

endmodule

// File: rtl/vx_tex_req_arb.sv
// -----------------------------------------------------------------------------
// vx_tex_req_arb
// Round-robin arbiter of NUM_REQS texture request channels onto one texture
// unit request channel. The source index is appended below the input tag so
// responses can be routed back. Optional 2-entry skid buffer on the output.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   req_in         NUM_REQS request channels (slave)
//   req_out        single request channel, tag = {tag, src index} (master)
//   perf_stalls    cycles with output valid and not ready  (perf build only)
//   perf_reqs      forwarded output handshakes             (perf build only)
// Optional feature macro: VX_TEX_REQ_ARB_PERF_EN enables the perf counters.
// -----------------------------------------------------------------------------
module vx_tex_req_arb
    import vx_tex_req_arb_pkg::*;
#(
    parameter int NUM_REQS   = 4,
    parameter int NUM_LANES  = 4,
    parameter int TAG_WIDTH  = 8,
    parameter int OUT_BUF    = 1,
    parameter int DROP_EMPTY = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    vx_tex_req_arb_if.slave          req_in,
    vx_tex_req_arb_if.master         req_out
`ifdef VX_TEX_REQ_ARB_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0] perf_stalls,
    output logic [PERF_CTR_BITS-1:0] perf_reqs
`endif
);

    localparam int SEL_BITS = sel_bits(NUM_REQS);
    localparam int PTR_W    = (SEL_BITS > 0) ? SEL_BITS : 1;
    localparam int OUT_TAGW = TAG_WIDTH + SEL_BITS;
    localparam int COORD_W  = 2 * NUM_LANES * 32;
    localparam int LOD_W    = NUM_LANES * TEX_LOD_BITS;
    localparam int DATAW    = NUM_LANES + COORD_W + LOD_W + TEX_STAGE_BITS + OUT_TAGW;

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     gnt_idx;
    logic [PTR_W-1:0]     cand;
    logic                 found;
    logic [NUM_LANES-1:0] sel_mask;
    logic [OUT_TAGW-1:0]  sel_tag;
    logic [DATAW-1:0]     sel_data;
    logic                 drop;
    logic                 stage_ready;
    logic                 fwd_valid;
    logic                 in_fire;
    logic                 out_valid;
    logic [DATAW-1:0]     out_data;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQS);
            if (req_in.valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign sel_mask = req_in.mask[gnt_idx];

    generate
        if (SEL_BITS > 0) begin : g_tag_idx
            assign sel_tag = {req_in.tag[gnt_idx], gnt_idx[SEL_BITS-1:0]};
        end else begin : g_tag_pass
            assign sel_tag = req_in.tag[gnt_idx];
        end
    endgenerate

    assign sel_data = {sel_mask, req_in.coords[gnt_idx], req_in.lod[gnt_idx],
                       req_in.stage[gnt_idx], sel_tag};

    // Empty-mask requests are swallowed here, so they never wait on the output.
    assign drop      = (DROP_EMPTY != 0) && found && (sel_mask == '0);
    assign fwd_valid = reset_n && found && !drop;
    assign in_fire   = reset_n && found && (drop || stage_ready);

    always_comb begin
        req_in.ready = '0;
        if (in_fire) req_in.ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (in_fire) begin
            rr_ptr <= (gnt_idx == PTR_W'(NUM_REQS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    generate
        if (OUT_BUF != 0) begin : g_out_buf
            vx_tex_skid_buf #(
                .DATAW (DATAW)
            ) u_skid (
                .clk       (clk),
                .reset_n   (reset_n),
                .in_valid  (fwd_valid),
                .in_data   (sel_data),
                .in_ready  (stage_ready),
                .out_valid (out_valid),
                .out_data  (out_data),
                .out_ready (req_out.ready[0])
            );
        end else begin : g_out_comb
            assign stage_ready = req_out.ready[0];
            assign out_valid   = fwd_valid;
            assign out_data    = sel_data;
        end
    endgenerate

    assign req_out.valid[0] = out_valid;
    assign {req_out.mask[0], req_out.coords[0], req_out.lod[0],
            req_out.stage[0], req_out.tag[0]} = out_data;

`ifdef VX_TEX_REQ_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stalls <= '0;
            perf_reqs   <= '0;
        end else begin
            if (out_valid && !req_out.ready[0]) perf_stalls <= perf_stalls + PERF_CTR_BITS'(1);
            if (out_valid && req_out.ready[0])  perf_reqs   <= perf_reqs + PERF_CTR_BITS'(1);
        end
    end
`endif

    // A requester left waiting at one edge must still be valid at the next.
    logic [NUM_REQS-1:0] pend_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else begin
            hold_valid: assert ((pend_q & ~req_in.valid) == '0);
            pend_q <= req_in.valid & ~req_in.ready;
        end
    end

endmodule

// File: tb/tb_vx_tex_req_arb.sv
module tb_vx_tex_req_arb;
    import vx_tex_req_arb_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    int   accepted;
    logic acc_now;
    logic [9:0] rr_exp [5];

    vx_tex_req_arb_if #(.N(4), .LANES(4), .TAGW(8))  req_in ();
    vx_tex_req_arb_if #(.N(1), .LANES(4), .TAGW(10)) req_out ();

`ifdef VX_TEX_REQ_ARB_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_stalls, perf_reqs;
`endif

    vx_tex_req_arb #(
        .NUM_REQS   (4),
        .NUM_LANES  (4),
        .TAG_WIDTH  (8),
        .OUT_BUF    (1),
        .DROP_EMPTY (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_in      (req_in),
        .req_out     (req_out)
`ifdef VX_TEX_REQ_ARB_PERF_EN
        ,
        .perf_stalls (perf_stalls),
        .perf_reqs   (perf_reqs)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [3:0] m, input logic [7:0] t);
        req_in.valid[ch]  = v;
        req_in.mask[ch]   = m;
        req_in.tag[ch]    = t;
        req_in.coords[ch] = {8{24'hC00000, t}};
        req_in.lod[ch]    = {4{4'(ch)}};
        req_in.stage[ch]  = 2'(ch);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rr_exp[0] = 10'h040; rr_exp[1] = 10'h045; rr_exp[2] = 10'h04A;
        rr_exp[3] = 10'h04F; rr_exp[4] = 10'h040;

        // Reset with every channel requesting
        reset_n = 1'b0;
        req_out.ready = 1'b1;
        for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 4'hF, 8'(8'h10 + c));
        tick();
        tick();
        chk("rst_ready", 64'(req_in.ready), 64'h0);
        chk("rst_out_valid", 64'(req_out.valid), 64'h0);
        reset_n = 1'b1;
        #1;
        chk("rel_ready", 64'(req_in.ready), 64'h1);

        // Round-robin, one output per cycle after the first
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_valid", 64'(req_out.valid), 64'h1);
            chk("rr_tag", 64'(req_out.tag[0]), 64'(rr_exp[k]));
        end

        reset_n = 1'b0;
        req_in.valid = '0;
        tick();
        reset_n = 1'b1;

        // Backpressure on channel 2
        req_out.ready = 1'b0;
        set_ch(2, 1'b1, 4'hF, 8'h5A);
        #1;
        chk("bp_first_ready", 64'(req_in.ready), 64'h4);
        accepted = 0;
        for (int k = 0; k < 5; k++) begin
            acc_now = req_in.valid[2] && req_in.ready[2];
            tick();
            if (acc_now) begin
                accepted++;
                req_in.tag[2] = (accepted == 1) ? 8'h5B : 8'h5C;
            end
            #1;
        end
        chk("bp_accepted", 64'(accepted), 64'd2);
        chk("bp_full_ready", 64'(req_in.ready), 64'h0);
        chk("bp_head_tag", 64'(req_out.tag[0]), 64'h16A);
        req_out.ready = 1'b1;
        #1;
        chk("bp_ready_registered", 64'(req_in.ready), 64'h0);
        tick();
        chk("bp_drain1_tag", 64'(req_out.tag[0]), 64'h16E);
        tick();
        chk("bp_drain2_tag", 64'(req_out.tag[0]), 64'h172);
        req_in.valid[2] = 1'b0;
        tick();
        chk("bp_drained", 64'(req_out.valid), 64'h0);

        // Empty-mask drop on channel 1 (pointer now 3)
        set_ch(1, 1'b1, 4'h0, 8'h21);
        #1;
        chk("drop_ready", 64'(req_in.ready), 64'h2);
        tick();
        set_ch(1, 1'b1, 4'h3, 8'h22);
        #1;
        chk("drop_no_out", 64'(req_out.valid), 64'h0);
        chk("drop_next_ready", 64'(req_in.ready), 64'h2);
        tick();
        chk("drop_fwd_valid", 64'(req_out.valid), 64'h1);
        chk("drop_fwd_mask", 64'(req_out.mask[0]), 64'h3);
        chk("drop_fwd_tag", 64'(req_out.tag[0]), 64'h089);
        chk("drop_fwd_lod", 64'(req_out.lod[0]), 64'h1111);
        chk("drop_fwd_stage", 64'(req_out.stage[0]), 64'h1);
        chk("drop_fwd_coord", 64'(req_out.coords[0][0][0]), 64'hC0000022);
        req_in.valid[1] = 1'b0;
        tick();
        chk("drop_idle", 64'(req_out.valid), 64'h0);

        // Simultaneous push/pop with one entry held (pointer now 2)
        req_out.ready = 1'b0;
        set_ch(0, 1'b1, 4'hF, 8'h30);
        #1;
        chk("pp_grant", 64'(req_in.ready), 64'h1);
        tick();
        req_in.tag[0] = 8'h31;
        req_out.ready = 1'b1;
        #1;
        chk("pp_ready", 64'(req_in.ready), 64'h1);
        chk("pp_head_tag", 64'(req_out.tag[0]), 64'h0C0);
        tick();
        req_in.valid[0] = 1'b0;
        chk("pp_valid", 64'(req_out.valid), 64'h1);
        chk("pp_second_tag", 64'(req_out.tag[0]), 64'h0C4);
        tick();
        chk("pp_occupancy_one", 64'(req_out.valid), 64'h0);

        // Fill both entries, then reset asynchronously mid-cycle (pointer now 1)
        req_out.ready = 1'b0;
        set_ch(3, 1'b1, 4'hF, 8'h40);
        #1;
        chk("full_grant", 64'(req_in.ready), 64'h8);
        tick();
        req_in.tag[3] = 8'h41;
        #1;
        tick();
        req_in.tag[3] = 8'h42;
        #1;
        chk("full_ready", 64'(req_in.ready), 64'h0);
        chk("full_head_tag", 64'(req_out.tag[0]), 64'h103);
        set_ch(1, 1'b1, 4'h0, 8'h50);
        #1;
        chk("drop_when_full", 64'(req_in.ready), 64'h2);
        tick();
        req_in.valid[1] = 1'b0;
        #1;
        chk("pre_rst_valid", 64'(req_out.valid), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(req_out.valid), 64'h0);
        chk("mid_rst_ready", 64'(req_in.ready), 64'h0);
        req_in.valid = '0;
`ifdef VX_TEX_REQ_ARB_PERF_EN
        chk("perf_stalls_rst", 64'(perf_stalls), 64'h0);
        chk("perf_reqs_rst", 64'(perf_reqs), 64'h0);
`endif
        tick();
        reset_n = 1'b1;
        req_out.ready = 1'b1;
        tick();
        chk("no_stale_1", 64'(req_out.valid), 64'h0);
        tick();
        chk("no_stale_2", 64'(req_out.valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
